// File: rtl/wb_arbiter.sv
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Per-channel result FIFOs with round-robin arbitration into one
//             registered writeback / bypass / commit port. Optional perf
//             counters enabled by defining WB_PERF_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int DEPTH    = 2,
  parameter int RESULT_W = 64,
  parameter int PC_W     = 64,
  parameter int INSTR_W  = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*5-1:0]          in_rd,
  input  logic [NUM_CH-1:0]            in_need_to_wb,
  input  logic [NUM_CH-1:0]            in_mmio,
  input  logic [NUM_CH*RESULT_W-1:0]   in_result,
  input  logic [NUM_CH*PC_W-1:0]       in_pc,
  input  logic [NUM_CH*INSTR_W-1:0]    in_instr,
  input  logic                         flush,
  output logic                         regfile_write_valid,
  output logic [4:0]                   regfile_write_rd,
  output logic [RESULT_W-1:0]          regfile_write_data,
  output logic                         byp_valid,
  output logic [4:0]                   byp_rd,
  output logic [RESULT_W-1:0]          byp_result,
  output logic                         commit_valid,
  output logic                         commit_skip,
  output logic [PC_W-1:0]              commit_pc,
  output logic [INSTR_W-1:0]           commit_instr
`ifdef WB_PERF_CNT_EN
  ,
  output logic [63:0]                  perf_commit_cnt,
  output logic [63:0]                  perf_full_stall_cnt
`endif
);

  localparam int c_PTR_W    = $clog2(DEPTH);
  localparam int c_CNT_W    = c_PTR_W + 1;
  localparam int c_RR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_PC_LSB   = INSTR_W;
  localparam int c_RES_LSB  = INSTR_W + PC_W;
  localparam int c_MMIO_BIT = c_RES_LSB + RESULT_W;
  localparam int c_NEED_BIT = c_MMIO_BIT + 1;
  localparam int c_RD_LSB   = c_NEED_BIT + 1;
  localparam int c_ENTRY_W  = c_RD_LSB + 5;

  logic [NUM_CH-1:0]    w_req;
  logic [NUM_CH-1:0]    w_ready;
  logic [NUM_CH-1:0]    w_push;
  logic [NUM_CH-1:0]    w_pop;
  logic [c_ENTRY_W-1:0] w_head [NUM_CH];
  logic [c_RR_W-1:0]    w_rot_idx [NUM_CH];
  logic [c_RR_W-1:0]    r_rr_ptr;
  logic [c_RR_W-1:0]    w_gnt_idx;
  logic                 w_gnt_valid;
  logic [c_ENTRY_W-1:0] w_gnt_entry;

  logic                 r_commit_valid;
  logic                 r_wb_valid;
  logic                 r_skip;
  logic [4:0]           r_rd;
  logic [RESULT_W-1:0]  r_data;
  logic [PC_W-1:0]      r_pc;
  logic [INSTR_W-1:0]   r_instr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_ENTRY_W-1:0] w_entry;

    assign w_entry = {in_rd[5*g +: 5], in_need_to_wb[g], in_mmio[g],
                      in_result[RESULT_W*g +: RESULT_W],
                      in_pc[PC_W*g +: PC_W],
                      in_instr[INSTR_W*g +: INSTR_W]};

    // Ready comes from the count alone, so a full FIFO popped this cycle still refuses.
    assign w_ready[g]   = (r_count != c_CNT_W'(DEPTH));
    assign w_req[g]     = (r_count != '0);
    assign w_push[g]    = in_valid[g] & w_ready[g] & ~flush;
    assign w_pop[g]     = w_gnt_valid & (w_gnt_idx == c_RR_W'(g));
    assign w_head[g]    = r_mem[r_rd_ptr];
    assign w_rot_idx[g] = c_RR_W'((int'(r_rr_ptr) + g) % NUM_CH);

    always_ff @(posedge clock) begin
      if (w_push[g]) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[g]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[g])  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push[g], w_pop[g]})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Descending scan so the lowest rotated offset (closest to rr_ptr) wins.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_req[w_rot_idx[k]]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = w_rot_idx[k];
      end
    end
    if (flush) w_gnt_valid = 1'b0;
  end

  assign w_gnt_entry = w_head[w_gnt_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr       <= '0;
      r_commit_valid <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_skip         <= 1'b0;
      r_rd           <= '0;
      r_data         <= '0;
      r_pc           <= '0;
      r_instr        <= '0;
    end else begin
      r_commit_valid <= w_gnt_valid;
      r_wb_valid     <= w_gnt_valid & w_gnt_entry[c_NEED_BIT] & ~w_gnt_entry[c_MMIO_BIT]
                        & (w_gnt_entry[c_RD_LSB +: 5] != 5'd0);
      r_skip         <= w_gnt_valid & w_gnt_entry[c_MMIO_BIT];
      if (w_gnt_valid) begin
        r_rr_ptr <= (w_gnt_idx == c_RR_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
        r_rd     <= w_gnt_entry[c_RD_LSB +: 5];
        r_data   <= w_gnt_entry[c_RES_LSB +: RESULT_W];
        r_pc     <= w_gnt_entry[c_PC_LSB +: PC_W];
        r_instr  <= w_gnt_entry[INSTR_W-1:0];
      end
    end
  end

  assign in_ready            = w_ready;
  assign regfile_write_valid = r_wb_valid;
  assign regfile_write_rd    = r_rd;
  assign regfile_write_data  = r_data;
  assign byp_valid           = r_wb_valid;
  assign byp_rd              = r_rd;
  assign byp_result          = r_data;
  assign commit_valid        = r_commit_valid;
  assign commit_skip         = r_skip;
  assign commit_pc           = r_pc;
  assign commit_instr        = r_instr;

`ifdef WB_PERF_CNT_EN
  logic [63:0] r_perf_commit_cnt;
  logic [63:0] r_perf_stall_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_commit_cnt <= '0;
      r_perf_stall_cnt  <= '0;
    end else begin
      if (r_commit_valid)            r_perf_commit_cnt <= r_perf_commit_cnt + 64'd1;
      if (|(in_valid & ~w_ready))    r_perf_stall_cnt  <= r_perf_stall_cnt + 64'd1;
    end
  end

  assign perf_commit_cnt     = r_perf_commit_cnt;
  assign perf_full_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

`default_nettype wire
